// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin grant on ties, req/done handshake,
// variable memory latency with a saturating timeout that aborts with err.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_wr,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m0_done,
    output logic              m1_done,
    output logic              m0_err,
    output logic              m1_err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    state_t     state, next_state;
    logic       last;
    logic       cur_wr;
    logic       err_q;
    logic [7:0] timer;
    logic       grant_any;
    logic       grant_idx;
    logic       acc_timeout;

    always_comb begin
        grant_any   = m0_req | m1_req;
        grant_idx   = (m0_req && m1_req) ? ~last : m1_req;
        acc_timeout = ({1'b0, timer} + 9'd1) >= {1'b0, TIMEOUT_L};
        next_state  = state;
        unique case (state)
            IDLE:    if (grant_any) next_state = ACCESS;
            ACCESS:  if (mem_ack || acc_timeout) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Grant capture, completion bookkeeping and per-port read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= 1'b0;
            last      <= 1'b1;
            cur_wr    <= 1'b0;
            err_q     <= 1'b0;
            timer     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner     <= grant_idx;
                        last      <= grant_idx;
                        cur_wr    <= grant_idx ? m1_wr : m0_wr;
                        mem_addr  <= grant_idx ? m1_addr : m0_addr;
                        mem_wdata <= grant_idx ? m1_wdata : m0_wdata;
                        timer     <= '0;
                        err_q     <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        err_q <= 1'b0;
                        if (!cur_wr) begin
                            if (owner) m1_rdata <= mem_rdata;
                            else       m0_rdata <= mem_rdata;
                        end
                    end else if (acc_timeout) begin
                        err_q <= 1'b1;
                        timer <= TIMEOUT_L;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from state so they fall the instant rst rises
    assign mem_rd  = (state == ACCESS) && !cur_wr;
    assign mem_wr  = (state == ACCESS) && cur_wr;
    assign m0_done = (state == RESP) && !owner;
    assign m1_done = (state == RESP) && owner;
    assign m0_err  = m0_done && err_q;
    assign m1_err  = m1_done && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected
// completions; a monitor pops and compares on every done pulse.
module tb_mem_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] m0;
        logic [31:0] m1;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              req   [2];
    logic              wr    [2];
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              m0_done, m1_done, m0_err, m1_err;
    logic              mem_rd, mem_wr, mem_ack, owner;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    exp_t        sb [$];
    int          pass_cnt  = 0;
    int          check_cnt = 0;
    int          ack_delay = 1;
    logic        manual_ack = 1'b0;
    int          acc_cnt   = 0;
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    logic        both_seen = 1'b0;
    logic [15:0] cap_addr  = '0;
    logic [31:0] cap_wdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m1_req(req[1]),
        .m0_wr(wr[0]), .m1_wr(wr[1]),
        .m0_addr(addr[0]), .m1_addr(addr[1]),
        .m0_wdata(wdata[0]), .m1_wdata(wdata[1]),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_done(m0_done), .m1_done(m1_done),
        .m0_err(m0_err), .m1_err(m1_err),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .owner(owner)
    );

    assign mem_rdata = (mem_addr == 16'h0010) ? 32'hDEADBEEF : {16'hC0DE, mem_addr};

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic failNow(input string name);
        check_cnt++;
        $display("[TB] FAIL %s: event did not occur as expected", name);
    endtask

    task automatic pushExpect(input int p, input logic e, input logic [31:0] r0, input logic [31:0] r1);
        exp_t x;
        x.port = p; x.err = e; x.m0 = r0; x.m1 = r1;
        sb.push_back(x);
    endtask

    // Drives one request and holds it until that port's done pulse
    task automatic applyStimulus(input int p, input logic w, input logic [15:0] a,
                                 input logic [31:0] d, output int lat);
        req[p] = 1'b1; wr[p] = w; addr[p] = a; wdata[p] = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!((p == 1) ? m1_done : m0_done) && lat < 100);
        if (lat >= 100) failNow("done_wait_bound");
        req[p] = 1'b0;
    endtask

    task automatic runPort(input int p, input logic [15:0] base);
        int lat;
        for (int i = 0; i < 3; i++) applyStimulus(p, 1'b0, base + 16'(i), 32'h0, lat);
    endtask

    // Memory model: ack in the ack_delay-th strobe cycle (0 = never)
    always @(negedge clk) begin
        if (mem_rd && mem_wr) both_seen = 1'b1;
        if (mem_rd || mem_wr) begin
            acc_cnt++;
            if (mem_rd) rd_cycles++;
            else        wr_cycles++;
            if (acc_cnt == 1) begin
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
            end
            mem_ack = (ack_delay != 0) && (acc_cnt == ack_delay);
        end else begin
            acc_cnt = 0;
            mem_ack = manual_ack;
        end
    end

    exp_t mon_e;
    int   mon_idx;

    always @(negedge clk) begin
        if (!rst && (m0_done || m1_done)) begin
            if (m0_done && m1_done) failNow("done_both_ports");
            if (sb.size() == 0) begin
                failNow("unexpected_done");
            end else begin
                mon_e   = sb.pop_front();
                mon_idx = m1_done ? 1 : 0;
                checkOutput("done_port", 64'(mon_idx), 64'(mon_e.port));
                checkOutput("owner", 64'(owner), 64'(mon_e.port));
                checkOutput("err", 64'(mon_idx == 1 ? m1_err : m0_err), 64'(mon_e.err));
                checkOutput("m0_rdata", 64'(m0_rdata), 64'(mon_e.m0));
                checkOutput("m1_rdata", 64'(m1_rdata), 64'(mon_e.m1));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, lat0, lat1;
        rst = 1'b1;
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (2) @(negedge clk);
        checkOutput("reset_strobes", {62'd0, mem_rd, mem_wr}, 64'd0);
        checkOutput("reset_done_err_owner", {59'd0, m0_done, m1_done, m0_err, m1_err, owner}, 64'd0);
        checkOutput("reset_rdata", {m0_rdata, m1_rdata}, 64'd0);
        checkOutput("reset_mem_bus", {mem_addr, mem_wdata}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single read on m0");
        ack_delay = 1; rd_cycles = 0; wr_cycles = 0;
        pushExpect(0, 1'b0, 32'hDEADBEEF, 32'h0);
        applyStimulus(0, 1'b0, 16'h0010, 32'h0, lat);
        checkOutput("read_latency", 64'(lat), 64'd2);
        checkOutput("read_rd_cycles", 64'(rd_cycles), 64'd1);
        checkOutput("read_wr_cycles", 64'(wr_cycles), 64'd0);
        checkOutput("read_mem_addr", 64'(cap_addr), 64'h0010);
        @(negedge clk);

        $display("[TB] write with wait states on m1");
        ack_delay = 3; rd_cycles = 0; wr_cycles = 0;
        pushExpect(1, 1'b0, 32'hDEADBEEF, 32'h0);
        applyStimulus(1, 1'b1, 16'h0200, 32'h12345678, lat);
        checkOutput("write_latency", 64'(lat), 64'd4);
        checkOutput("write_wr_cycles", 64'(wr_cycles), 64'd3);
        checkOutput("write_rd_cycles", 64'(rd_cycles), 64'd0);
        checkOutput("write_mem_addr", 64'(cap_addr), 64'h0200);
        checkOutput("write_mem_wdata", 64'(cap_wdata), 64'h12345678);
        @(negedge clk);

        $display("[TB] contention from reset");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ack_delay = 1;
        pushExpect(0, 1'b0, 32'hC0DE0100, 32'h0);
        pushExpect(1, 1'b0, 32'hC0DE0100, 32'hC0DE0300);
        pushExpect(0, 1'b0, 32'hC0DE0101, 32'hC0DE0300);
        pushExpect(1, 1'b0, 32'hC0DE0101, 32'hC0DE0301);
        pushExpect(0, 1'b0, 32'hC0DE0102, 32'hC0DE0301);
        pushExpect(1, 1'b0, 32'hC0DE0102, 32'hC0DE0302);
        fork
            runPort(0, 16'h0100);
            runPort(1, 16'h0300);
        join
        @(negedge clk);

        $display("[TB] timeout on m0 read");
        ack_delay = 0; rd_cycles = 0; wr_cycles = 0;
        pushExpect(0, 1'b1, 32'hC0DE0102, 32'hC0DE0302);
        applyStimulus(0, 1'b0, 16'h0040, 32'h0, lat);
        checkOutput("timeout_latency", 64'(lat), 64'd5);
        checkOutput("timeout_rd_cycles", 64'(rd_cycles), 64'd4);
        @(negedge clk);

        $display("[TB] reset mid-access");
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h0050;
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_strobe", 64'(mem_rd), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_strobes", {62'd0, mem_rd, mem_wr}, 64'd0);
        checkOutput("rst_done_err_owner", {59'd0, m0_done, m1_done, m0_err, m1_err, owner}, 64'd0);
        checkOutput("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        checkOutput("rst_mem_bus", {mem_addr, mem_wdata}, 64'd0);
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] tie after reset");
        ack_delay = 1;
        pushExpect(0, 1'b0, 32'hC0DE0060, 32'h0);
        pushExpect(1, 1'b0, 32'hC0DE0060, 32'hC0DE0061);
        fork
            applyStimulus(0, 1'b0, 16'h0060, 32'h0, lat0);
            applyStimulus(1, 1'b0, 16'h0061, 32'h0, lat1);
        join
        checkOutput("tie_m0_latency", 64'(lat0), 64'd2);
        @(negedge clk);

        $display("[TB] ack while idle");
        manual_ack = 1'b1;
        repeat (3) @(negedge clk);
        manual_ack = 1'b0;
        @(negedge clk);
        checkOutput("idle_ack_strobes", {62'd0, mem_rd, mem_wr}, 64'd0);
        checkOutput("idle_ack_rdata", {m0_rdata, m1_rdata}, {32'hC0DE0060, 32'hC0DE0061});

        ack_delay = 1; rd_cycles = 0; wr_cycles = 0;
        pushExpect(0, 1'b0, 32'hC0DE0060, 32'hC0DE0061);
        applyStimulus(0, 1'b1, 16'h0070, 32'hCAFEF00D, lat);
        checkOutput("post_idle_latency", 64'(lat), 64'd2);
        checkOutput("post_idle_wr_cycles", 64'(wr_cycles), 64'd1);
        checkOutput("post_idle_wdata", 64'(cap_wdata), 64'hCAFEF00D);
        repeat (2) @(negedge clk);

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        checkOutput("strobe_exclusive", 64'(both_seen), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that lets the control unit's fetch/load/store traffic share the single memory port with a second bus master (DMA or debug loader). It grants the port to one requester at a time, breaks ties round-robin, and sequences each access as a req/done handshake. It tolerates variable memory latency and aborts an access that never completes. It sits between the requester-side bus logic and the memory's rd/wr/ack interface.

## Interface
- ADDR_W, 16, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles waiting for mem_ack before abort (1..255)
- clk  in  1  clock, all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- m0_req, m1_req  in  1  requester holds high until its done pulse
- m0_wr, m1_wr  in  1  1 = write, 0 = read; stable while req high
- m0_addr, m1_addr  in  ADDR_W  access address; stable while req high
- m0_wdata, m1_wdata  in  DATA_W  write data; stable while req high
- m0_rdata, m1_rdata  out  DATA_W  registered read data, valid from done onward
- m0_done, m1_done  out  1  one-cycle completion pulse
- m0_err, m1_err  out  1  high with done when the access timed out
- mem_rd, mem_wr  out  1  memory strobes, never both high
- mem_addr  out  ADDR_W  registered address of granted access
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion; may be high in the first ACCESS cycle
- owner  out  1  index of current/last granted requester

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if exactly one req is high, grant it. If both are high, grant the one that is not `last`. `last` resets to 1, so m0 wins the first tie. On grant, register owner, wr, addr and wdata, set `last` = granted index, clear the timer, and go to ACCESS. With no req, stay in IDLE.
- ACCESS: drive mem_rd = !wr, mem_wr = wr, and hold mem_addr/mem_wdata.
  - On mem_ack: for a read, latch mem_rdata into the owner's rdata. Go to RESP with err = 0.
  - Without mem_ack: increment the timer. When the timer reaches TIMEOUT, go to RESP with err = 1 and leave rdata unchanged.
- RESP: pulse done (and err if set) for the owner only, then return to IDLE. Strobes are low.
- Requester rule: drop req by the cycle after done. A req still high in the following IDLE cycle is a new transaction.
- A req arriving in ACCESS/RESP waits and is arbitrated in the next IDLE.
- rdata of a port changes only on a successful read completion for that port.
- Writes never modify either rdata register.

## Timing
- Reset (async, immediate): state IDLE, all outputs 0, last = 1, timer 0, m0/m1_rdata 0. The strobes drop the moment rst rises, so an access in flight is abandoned with no done.
- Minimum latency, req high in IDLE cycle 0:
  - cycle 1: ACCESS, strobe high.
  - ack in cycle 1 → cycle 2: RESP, done = 1, rdata valid.
  - cycle 3: IDLE.
- Back-to-back throughput is one access per 3 cycles plus memory wait cycles.
- Strobe duration is exactly the number of ACCESS cycles: min 1, max TIMEOUT.
- Timeout: the strobe stays high for TIMEOUT cycles, then RESP with err = 1.
- mem_ack outside ACCESS is ignored.
- Both reqs rising in the same IDLE cycle: the non-`last` port is granted. The other port is granted at the earliest in the IDLE after the first port's RESP.
- Width rules:
  - The timer is 8 bits and saturates at TIMEOUT; no wrap.
  - The arbiter passes addresses through unmodified; there is no address arithmetic.

## Test plan
- Single read: m0_req, wr = 0, addr = 0x0010, mem returns 0xDEADBEEF with ack in the first ACCESS cycle. Required: mem_rd high 1 cycle, m0_done 2 cycles after req, m0_rdata = 0xDEADBEEF, m1_rdata = 0.
- Write with wait states: m1_req, wr = 1, addr = 0x0200, wdata = 0x12345678, ack after 3 cycles. Required: mem_wr high 3 cycles, mem_addr = 0x0200, mem_wdata = 0x12345678, m1_done with m1_err = 0, both rdata unchanged.
- Contention from reset: m0 and m1 req together, each holding req for 3 transactions. Required: grants alternate m0, m1, m0, m1, m0, m1, and owner tracks each grant.
- Timeout: TIMEOUT = 4, m0 read, no ack. Required: mem_rd high exactly 4 cycles, then m0_done = m0_err = 1, m0_rdata unchanged.
- Reset mid-access: assert rst during the second ACCESS cycle. Required: mem_rd/mem_wr 0 immediately, no done, all outputs 0. After release, m0 wins the next tie.
- Late ack: pulse mem_ack in IDLE with no req. Required: no done, rdata unchanged, state stays IDLE.
